mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the COA CPU datapath. Accepts read/write commands carried on the CON control word, using the address from the memory address register and the write data from the memory buffer register. Holds a 256×16 word store, applies a programmable access latency, and returns read data to the MBR with a one-cycle acknowledge. It is the far end of the MAR→memory address path and the source of the memory→MBR data path.

## Interface
- LAT, default 1: wait cycles inserted before an access completes; range 0..15.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CON  in  32  control word:
  - CON[2] = memory write (MBR→M).
  - CON[3] = memory read (M→MBR).
  - All other bits are ignored.
- MAR_IN  in  8  word address.
- MBR_IN  in  16  write data.
- MEM_OUT  out  16  read data to MBR; reset 0.
- BUSY  out  1  high while a command is in flight; reset 0.
- ACK  out  1  single-cycle completion pulse for reads and writes; reset 0.
- PERR  out  1  parity error on the completed read; reset 0; tied 0 unless RAM_PARITY_EN.

## Operation
- States: IDLE, WAIT. 2-bit encoding; IDLE=0.
- IDLE:
  - At a rising edge with CON[2] or CON[3] high, latch MAR_IN, MBR_IN and the op.
  - Load the counter with LAT, set BUSY=1, go to WAIT.
- Both strobes high at acceptance: the write is performed and the read is dropped. No ACK for the dropped read.
- WAIT, counter ≠ 0: decrement the counter.
- WAIT, counter = 0: perform the access, drive ACK=1 and BUSY=0, go to IDLE.
  - Write: store the latched data at the latched address; MEM_OUT is unchanged.
  - Read: load MEM_OUT with the word at the latched address.
- ACK is high for exactly one cycle. In the cycle after it is cleared, IDLE may already accept a new command (back-to-back).
- Strobes arriving while BUSY=1 are ignored, not queued. Changes to MAR_IN and MBR_IN during WAIT have no effect.
- MEM_OUT holds its value until the next completed read.
- The storage array is not cleared by RST and is zero-initialised for simulation.
- RST mid-operation:
  - Aborts the command; the pending write is not performed.
  - Returns to IDLE; MEM_OUT=0, BUSY=0, ACK=0, PERR=0.
- Address wrap: none needed; the 8-bit address covers all 256 words.

## Timing
- Command sampled at edge k → ACK high from edge k+LAT+1 until edge k+LAT+2.
- LAT=0: ACK in the cycle immediately following acceptance.
- Read data: MEM_OUT and PERR are valid in the same cycle as ACK. Downstream MBR captures on that edge.
- BUSY is high from edge k through edge k+LAT+1, i.e. for LAT+1 cycles.
- Maximum throughput: one command per LAT+2 cycles.
- Read after write to the same address, issued back-to-back: returns the new data. The write commits before the next accept.

## Configuration
- RAM_PARITY_EN:
  - Defined:
    - Each word stores a 17th bit equal to the XOR of its 16 data bits, written on every write.
    - On read completion, PERR = stored parity XOR recomputed parity, registered alongside MEM_OUT.
    - PERR is cleared at the next read completion.
  - Undefined: the array is 16 bits wide and PERR is constant 0.
  - Port list is identical in both builds.

## Structure
- Shared package coa_cpu_pkg holds:
  - CON bit indices MEM_WR_BIT=2 and MEM_RD_BIT=3.
  - ADDR_W=8 and DATA_W=16.
  - State encoding IDLE/WAIT.
- Sub-module mem_array_256x16: a synchronous-write, registered-read storage array. Its width is 17 under RAM_PARITY_EN.
- The top level holds the FSM, the latency counter and the command latches.

## Test plan
1. Reset: RST pulse mid-WAIT on a write of 0x1234 to 0x10 → outputs go 0 immediately; a later read of 0x10 returns 0x0000.
2. LAT=1:
   - Write 0xBEEF to 0x05 at edge 0 → ACK high only for the cycle after edge 2, and MEM_OUT stays 0.
   - Read of 0x05 → MEM_OUT=0xBEEF with ACK.
3. Back-to-back: LAT=0, write 0xA5A5 to 0xFF, then a read of 0xFF accepted the cycle after ACK → returns 0xA5A5. Strobes pulsed during BUSY produce no extra ACK.
4. Simultaneous strobes: CON[2]=CON[3]=1, address 0x20, MBR_IN=0x0F0F → a single ACK, MEM_OUT unchanged, and a later read returns 0x0F0F.
5. LAT=15: a read of 0x00 → BUSY high for 16 cycles, ACK at acceptance edge + 16.
6. RAM_PARITY_EN:
   - Write 0x0001 to 0x40, then backdoor-flip data bit 3 in the array → a read returns 0x0009 with PERR=1.
   - The following read of 0x41 gives PERR=0.

Source files
------------

// File: rtl/coa_cpu_pkg.sv
// Shared COA CPU definitions: CON control-word bit positions, datapath widths
// and the memory responder state encoding.
package coa_cpu_pkg;

    localparam int CON_W      = 32;
    localparam int MEM_WR_BIT = 2;
    localparam int MEM_RD_BIT = 3;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Memory command/response bundle between the CPU datapath (master) and the
// memory responder (slave).
interface mem_responder_if;
    import coa_cpu_pkg::*;

    logic [CON_W-1:0]  CON;
    logic [ADDR_W-1:0] MAR_IN;
    logic [DATA_W-1:0] MBR_IN;
    logic [DATA_W-1:0] MEM_OUT;
    logic              BUSY;
    logic              ACK;
    logic              PERR;

    modport master (
        output CON, MAR_IN, MBR_IN,
        input  MEM_OUT, BUSY, ACK, PERR
    );

    modport slave (
        input  CON, MAR_IN, MBR_IN,
        output MEM_OUT, BUSY, ACK, PERR
    );

endinterface

// File: rtl/mem_array_256x16.sv
// 256-word store with synchronous write and registered read port.
// With RAM_PARITY_EN each word carries an extra even-parity bit and perr_o flags a mismatch.
module mem_array_256x16
    import coa_cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              perr_o
);

`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_q;
    logic [WORD_W-1:0] word_in;

`ifdef RAM_PARITY_EN
    assign word_in = {^wdata_i, wdata_i};
    // stored parity against parity of the returned data, both from the read register
    assign perr_o  = rd_q[DATA_W] ^ (^rd_q[DATA_W-1:0]);
`else
    assign word_in = wdata_i;
    assign perr_o  = 1'b0;
`endif

    assign rdata_o = rd_q[DATA_W-1:0];

    // contents survive reset; only the read register is cleared
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= word_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts CON read/write strobes, waits LAT cycles, then
// completes the access with a one-cycle ACK. Build option RAM_PARITY_EN enables word parity.
module mem_responder
    import coa_cpu_pkg::*;
#(
    parameter int unsigned LAT = 1
)
(
    input  logic            CLK,
    input  logic            RST,
    mem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAT_CNT = LAT[CNT_W-1:0];

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              op_wr_q;
    logic              busy_q;
    logic              ack_q;

    logic              wr_stb;
    logic              rd_stb;
    logic              done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_perr;
    logic              unused_con;

    assign wr_stb     = bus.CON[MEM_WR_BIT];
    assign rd_stb     = bus.CON[MEM_RD_BIT];
    assign unused_con = ^{bus.CON[CON_W-1:MEM_RD_BIT+1], bus.CON[MEM_WR_BIT-1:0]};
    assign done       = (state_q == WAIT) && (cnt_q == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_wr_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_stb || rd_stb) begin
                        addr_q  <= bus.MAR_IN;
                        data_q  <= bus.MBR_IN;
                        // a write with a simultaneous read strobe wins; the read is dropped
                        op_wr_q <= wr_stb;
                        cnt_q   <= LAT_CNT;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    mem_array_256x16 u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (done && op_wr_q),
        .re_i    (done && !op_wr_q),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (mem_rdata),
        .perr_o  (mem_perr)
    );

    assign bus.MEM_OUT = mem_rdata;
    assign bus.PERR    = mem_perr;
    assign bus.BUSY    = busy_q;
    assign bus.ACK     = ack_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three responders (LAT 0, 1, 15) share one command
// stream and are compared each cycle against a timestamp-based memory model.
module tb_mem_responder;
    import coa_cpu_pkg::*;

    localparam int NL = 3;
    localparam int LATS [NL] = '{0, 1, 15};

    logic        CLK;
    logic        RST;
    logic [31:0] con;
    logic [7:0]  mar;
    logic [15:0] mbr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus2 ();

    assign bus0.CON = con;  assign bus0.MAR_IN = mar;  assign bus0.MBR_IN = mbr;
    assign bus1.CON = con;  assign bus1.MAR_IN = mar;  assign bus1.MBR_IN = mbr;
    assign bus2.CON = con;  assign bus2.MAR_IN = mar;  assign bus2.MBR_IN = mbr;

    mem_responder #(.LAT(0))  u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    mem_responder #(.LAT(1))  u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
    mem_responder #(.LAT(15)) u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    logic [15:0] out_w  [NL];
    logic        ack_w  [NL];
    logic        busy_w [NL];
    logic        perr_w [NL];

    assign out_w[0] = bus0.MEM_OUT; assign ack_w[0] = bus0.ACK;
    assign busy_w[0] = bus0.BUSY;   assign perr_w[0] = bus0.PERR;
    assign out_w[1] = bus1.MEM_OUT; assign ack_w[1] = bus1.ACK;
    assign busy_w[1] = bus1.BUSY;   assign perr_w[1] = bus1.PERR;
    assign out_w[2] = bus2.MEM_OUT; assign ack_w[2] = bus2.ACK;
    assign busy_w[2] = bus2.BUSY;   assign perr_w[2] = bus2.PERR;

    // reference: word store as {parity, data}, one pending command per lane with its completion cycle
    logic [16:0] mdl_mem [NL][256];
    bit          pend    [NL];
    int          done_at [NL];
    bit          p_wr    [NL];
    logic [7:0]  p_addr  [NL];
    logic [15:0] p_data  [NL];
    logic [15:0] e_out   [NL];
    logic        e_ack   [NL];
    logic        e_busy  [NL];
    logic        e_perr  [NL];

    int cyc;
    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("lat%0d ACK", LATS[l]),     32'(ack_w[l]),  32'(e_ack[l]));
            check($sformatf("lat%0d BUSY", LATS[l]),    32'(busy_w[l]), 32'(e_busy[l]));
            check($sformatf("lat%0d MEM_OUT", LATS[l]), 32'(out_w[l]),  32'(e_out[l]));
            check($sformatf("lat%0d PERR", LATS[l]),    32'(perr_w[l]), 32'(e_perr[l]));
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int l = 0; l < NL; l++) begin
            e_ack[l] = 1'b0;
            if (pend[l]) begin
                if (cyc == done_at[l]) begin
                    if (p_wr[l]) begin
                        mdl_mem[l][p_addr[l]] = {^p_data[l], p_data[l]};
                    end else begin
                        e_out[l]  = mdl_mem[l][p_addr[l]][15:0];
                        e_perr[l] = ^mdl_mem[l][p_addr[l]];
                    end
                    e_ack[l]  = 1'b1;
                    e_busy[l] = 1'b0;
                    pend[l]   = 1'b0;
                end
            end else if (con[2] || con[3]) begin
                pend[l]    = 1'b1;
                p_wr[l]    = con[2];
                p_addr[l]  = mar;
                p_data[l]  = mbr;
                done_at[l] = cyc + LATS[l] + 1;
                e_busy[l]  = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [31:0] c, input logic [7:0] a, input logic [15:0] d);
        con = c;
        mar = a;
        mbr = d;
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int k);
        repeat (k) step(32'h0, 8'($urandom), 16'($urandom));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        for (int l = 0; l < NL; l++) begin
            pend[l]   = 1'b0;
            e_out[l]  = '0;
            e_ack[l]  = 1'b0;
            e_busy[l] = 1'b0;
            e_perr[l] = 1'b0;
        end
        check_all();
        #1;
        RST = 1'b0;
    endtask

    localparam logic [31:0] WR = 32'h4;
    localparam logic [31:0] RD = 32'h8;

    initial begin
        logic [31:0] c;
        logic [7:0]  a;
        int          r;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        con = '0; mar = '0; mbr = '0;
        for (int l = 0; l < NL; l++) begin
            for (int w = 0; w < 256; w++) mdl_mem[l][w] = '0;
            pend[l] = 1'b0; e_out[l] = '0; e_ack[l] = 1'b0;
            e_busy[l] = 1'b0; e_perr[l] = 1'b0; done_at[l] = 0;
            p_wr[l] = 1'b0; p_addr[l] = '0; p_data[l] = '0;
        end

        RST = 1'b0;
        #1 RST = 1'b1;
        #1 check_all();
        @(posedge CLK);
        #1 RST = 1'b0;
        idle(1);

        // write aborted by reset mid-WAIT never lands
        step(WR, 8'h10, 16'h1234);
        do_reset();
        idle(2);
        step(RD, 8'h10, 16'h0);
        idle(17);

        step(WR, 8'h05, 16'hBEEF);
        idle(17);
        step(RD, 8'h05, 16'h0);
        idle(17);

        // back-to-back write/read plus strobes while busy
        step(WR, 8'hFF, 16'hA5A5);
        idle(1);
        step(RD, 8'hFF, 16'h0);
        step(WR, 8'h07, 16'h1111);
        step(RD, 8'h07, 16'h0);
        step(WR | RD, 8'h08, 16'h2222);
        idle(18);

        step(WR | RD, 8'h20, 16'h0F0F);
        idle(17);
        step(RD, 8'h20, 16'h0);
        idle(17);

        step(RD | 32'hFFFF_FFF3, 8'h00, 16'hFFFF);
        idle(17);

`ifdef RAM_PARITY_EN
        step(WR, 8'h40, 16'h0001);
        step(WR, 8'h41, 16'h0003);
        idle(17);
        u_dut0.u_mem.mem_q[8'h40][3] = ~u_dut0.u_mem.mem_q[8'h40][3];
        u_dut1.u_mem.mem_q[8'h40][3] = ~u_dut1.u_mem.mem_q[8'h40][3];
        u_dut2.u_mem.mem_q[8'h40][3] = ~u_dut2.u_mem.mem_q[8'h40][3];
        for (int l = 0; l < NL; l++) mdl_mem[l][8'h40][3] = ~mdl_mem[l][8'h40][3];
        step(RD, 8'h40, 16'h0);
        idle(17);
        step(RD, 8'h41, 16'h0);
        idle(17);
`endif

        for (int i = 0; i < 600; i++) begin
            c = $urandom & 32'hFFFF_FFF3;
            r = $urandom_range(0, 9);
            if (r < 2)       c = c | WR;
            else if (r < 4)  c = c | RD;
            else if (r == 4) c = c | WR | RD;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            step(c, a, 16'($urandom));
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        idle(18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
